// File: rtl/async_fifo_wr_ctrl_pkg.sv
// Shared async-FIFO helpers: pointer-width rule and Gray/binary conversions.
// Conversions work on 32-bit zero-extended values; callers truncate to pointer width.
package async_fifo_wr_ctrl_pkg;

  // Pointers carry one extra wrap bit beyond the RAM address.
  function automatic int ptr_width(input int address_width);
    return address_width + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    logic        acc;
    bin = '0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side FIFO bundle: producer request, synchronized read pointer, RAM/flag outputs.
interface async_fifo_wr_ctrl_if
  import async_fifo_wr_ctrl_pkg::*;
#(
  parameter int AddressWidth = 16
);
  localparam int PtrWidth = ptr_width(AddressWidth);

  logic                    wr_en;
  logic [PtrWidth-1:0]     rptr_sync;
  logic                    wr_fire;
  logic [AddressWidth-1:0] waddr;
  logic [PtrWidth-1:0]     wptr_gray;
  logic                    full;
  logic                    almost_full;
  logic [PtrWidth-1:0]     wr_level;

  // Producer / surrounding FIFO side.
  modport master (
    output wr_en, rptr_sync,
    input  wr_fire, waddr, wptr_gray, full, almost_full, wr_level
  );

  // Write controller side.
  modport slave (
    input  wr_en, rptr_sync,
    output wr_fire, waddr, wptr_gray, full, almost_full, wr_level
  );
endinterface

// File: rtl/async_fifo_wr_ctrl_gray2bin.sv
// Parameterized combinational Gray-to-binary converter (XOR prefix from the MSB down).
module async_fifo_wr_ctrl_gray2bin #(
  parameter int Width = 17
) (
  input  logic [Width-1:0] gray,
  output logic [Width-1:0] bin
);
  logic acc;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end
endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain pointer and flag controller for the asynchronous FIFO.
// Publishes a registered Gray write pointer and pessimistic full/almost-full/level flags.
module async_fifo_wr_ctrl
  import async_fifo_wr_ctrl_pkg::*;
#(
  parameter int AddressWidth     = 16,
  parameter int AlmostFullMargin = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  async_fifo_wr_ctrl_if.slave  bus
);
  localparam int PtrWidth = ptr_width(AddressWidth);
  localparam longint unsigned Depth = longint'(1) << AddressWidth;
  localparam logic [PtrWidth-1:0] AfThreshold = PtrWidth'(Depth - longint'(AlmostFullMargin));

  logic [PtrWidth-1:0] wbin;
  logic [PtrWidth-1:0] wbin_next;
  logic [PtrWidth-1:0] wgray_next;
  logic [PtrWidth-1:0] wgray_q;
  logic [PtrWidth-1:0] rbin;
  logic [PtrWidth-1:0] level_next;
  logic [PtrWidth-1:0] level_q;
  logic                full_q;
  logic                full_next;
  logic                almost_full_q;
  logic                wr_fire;

  // Gating with rst keeps the RAM from capturing while reset is held.
  assign wr_fire    = bus.wr_en & ~full_q & ~rst;
  assign wbin_next  = wbin + PtrWidth'(wr_fire);
  assign wgray_next = PtrWidth'(bin2gray(32'(wbin_next)));

  async_fifo_wr_ctrl_gray2bin #(
    .Width (PtrWidth)
  ) u_rptr_g2b (
    .gray (bus.rptr_sync),
    .bin  (rbin)
  );

  assign level_next = wbin_next - rbin;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_next = (wgray_next ==
                      {~bus.rptr_sync[PtrWidth-1:PtrWidth-2], bus.rptr_sync[PtrWidth-3:0]});

  // NOTE: sequential state uses non-blocking assignments and the asynchronous reset
  // clears every register so all outputs drop to 0 as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin          <= '0;
      wgray_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      level_q       <= '0;
    end else begin
      wbin          <= wbin_next;
      wgray_q       <= wgray_next;
      full_q        <= full_next;
      almost_full_q <= (level_next >= AfThreshold);
      level_q       <= level_next;
    end
  end

  assign bus.wr_fire     = wr_fire;
  assign bus.waddr       = wbin[AddressWidth-1:0];
  assign bus.wptr_gray   = wgray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.wr_level    = level_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Self-checking bench for async_fifo_wr_ctrl: directed plan items plus random traffic
// compared against a counter-based occupancy model.
module tb_async_fifo_wr_ctrl;
  localparam int AW     = 2;
  localparam int MARGIN = 1;
  localparam int DEPTH  = 1 << AW;
  localparam int PMOD   = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  async_fifo_wr_ctrl_if #(.AddressWidth(AW)) bus ();

  async_fifo_wr_ctrl #(
    .AddressWidth     (AW),
    .AlmostFullMargin (MARGIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;  // writes accepted since reset
  int rcnt  = 0;  // reads published on rptr_sync since reset

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] gray_of(input int n);
    int b;
    b = n % PMOD;
    return 32'(b ^ (b >> 1));
  endfunction

  // Registered outputs, as seen after the last edge.
  task automatic check_regs(input string tag);
    int occ;
    occ = wcnt - rcnt;
    check({tag, ".full"},  32'(bus.full),        32'(occ == DEPTH));
    check({tag, ".level"}, 32'(bus.wr_level),    32'(occ));
    check({tag, ".af"},    32'(bus.almost_full), 32'(occ >= DEPTH - MARGIN));
    check({tag, ".gray"},  32'(bus.wptr_gray),   gray_of(wcnt));
  endtask

  // One clock: called just after a falling edge, returns just after the next one.
  task automatic step(input bit we, input bit adv);
    bit was_full;
    bit fire;
    check_regs("reg");
    was_full = ((wcnt - rcnt) == DEPTH);
    bus.wr_en = we;
    if (adv && rcnt < wcnt) rcnt++;
    bus.rptr_sync = 3'(gray_of(rcnt));
    #1;
    fire = we && !was_full;
    check("wr_fire", 32'(bus.wr_fire), 32'(fire));
    check("waddr",   32'(bus.waddr),   32'(wcnt % DEPTH));
    @(posedge clk);
    if (fire) wcnt++;
    @(negedge clk);
  endtask

  initial begin
    int fill_gray [4] = '{1, 3, 2, 6};
    int wrap_gray [8] = '{1, 3, 2, 6, 7, 5, 4, 0};

    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.rptr_sync = '0;
    #1;
    check("por.full",  32'(bus.full),      32'd0);
    check("por.level", 32'(bus.wr_level),  32'd0);
    check("por.af",    32'(bus.almost_full), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill from empty.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check("fill.gray", 32'(bus.wptr_gray), 32'(fill_gray[i]));
      if (i == 2) check("fill.af3", 32'(bus.almost_full), 32'd1);
    end
    check("fill.full",  32'(bus.full),     32'd1);
    check("fill.level", 32'(bus.wr_level), 32'd4);

    // Overflow attempt.
    step(1'b1, 1'b0);
    check("ovf.gray",  32'(bus.wptr_gray), 32'd6);
    check("ovf.waddr", 32'(bus.waddr),     32'd0);

    // Release by one read, then accept a write at address 0.
    step(1'b0, 1'b1);
    check("rel.full",  32'(bus.full),     32'd0);
    check("rel.level", 32'(bus.wr_level), 32'd3);
    check("rel.waddr", 32'(bus.waddr),    32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("sim.pre", 32'(bus.wr_level), 32'd3);
    step(1'b1, 1'b1);
    check("sim.level", 32'(bus.wr_level), 32'd3);

    // Asynchronous reset mid-cycle with a write pending.
    bus.wr_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst.fire",  32'(bus.wr_fire),     32'd0);
    check("rst.waddr", 32'(bus.waddr),       32'd0);
    check("rst.gray",  32'(bus.wptr_gray),   32'd0);
    check("rst.full",  32'(bus.full),        32'd0);
    check("rst.af",    32'(bus.almost_full), 32'd0);
    check("rst.level", 32'(bus.wr_level),    32'd0);
    bus.wr_en     = 1'b0;
    bus.rptr_sync = '0;
    wcnt = 0;
    rcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    check_regs("post_rst");

    // Wrap with reads trailing one behind.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      check("wrap.gray", 32'(bus.wptr_gray), 32'(wrap_gray[i]));
      check("wrap.full", 32'(bus.full),      32'd0);
    end

    // Random traffic against the occupancy model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end
    check_regs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
